// File: rtl/gno_disc_pkg.sv
// Shared constants, sample type and FSM state encoding for the
// discriminator request arbiter.
package gno_disc_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int CNT_W              = 9;
  localparam int DEF_SAMPLE_COUNT   = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1048576;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [2:0] {
    IDLE,
    STREAM,
    START,
    WAIT,
    READ,
    RESP
  } arb_state_t;

endpackage

// File: rtl/disc_request_arbiter_if.sv
// Bundle of source handshake, pipeline FIFO/control and result signals
// seen by the discriminator request arbiter.
interface disc_request_arbiter_if;
  import gno_disc_pkg::*;

  logic [1:0] req;
  logic [1:0] grant;
  logic [1:0] s_valid;
  logic [1:0] s_ready;
  sample_t    s_data0;
  sample_t    s_data1;
  logic       disc_wr_en;
  sample_t    disc_wr_data;
  logic       disc_full;
  logic       disc_start;
  logic       disc_done;
  logic       disc_real_flag;
  logic       score_rd_en;
  sample_t    score_rd_data;
  logic       score_rd_valid;
  logic       score_empty;
  logic       res_valid;
  logic       res_src;
  sample_t    res_score;
  logic       res_real;
  logic       timeout_err;

  modport slave (
    input  req, s_valid, s_data0, s_data1, disc_full, disc_done, disc_real_flag,
           score_rd_data, score_rd_valid, score_empty,
    output grant, s_ready, disc_wr_en, disc_wr_data, disc_start, score_rd_en,
           res_valid, res_src, res_score, res_real, timeout_err
  );

  modport master (
    output req, s_valid, s_data0, s_data1, disc_full, disc_done, disc_real_flag,
           score_rd_data, score_rd_valid, score_empty,
    input  grant, s_ready, disc_wr_en, disc_wr_data, disc_start, score_rd_en,
           res_valid, res_src, res_score, res_real, timeout_err
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-request round-robin picker; the pointer moves to the source that was
// not served whenever update is pulsed.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       last_src,
  output logic [1:0] gnt
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (update) begin
      ptr <= ~last_src;
    end
  end

  always_comb begin
    gnt = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

endmodule

// File: rtl/disc_request_arbiter.sv
// Arbitrates two sample sources onto one discriminator pipeline: stream a
// block, start the pipeline, wait for its decision, read the score, report.
module disc_request_arbiter
  import gno_disc_pkg::*;
#(
  parameter int SAMPLE_COUNT   = DEF_SAMPLE_COUNT,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                   clk,
  input logic                   rst,
  disc_request_arbiter_if.slave bus
);

  localparam int                WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(SAMPLE_COUNT - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT  = WD_W'(TIMEOUT_CYCLES - 1);

  arb_state_t        state;
  logic [CNT_W-1:0]  word_cnt;
  logic [WD_W-1:0]   wdog;
  logic              src;
  logic              rd_issued;
  logic              real_lat;
  logic [1:0]        rr_gnt;
  logic [1:0]        ready;

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (bus.req),
    .update   (state == RESP),
    .last_src (src),
    .gnt      (rr_gnt)
  );

  // Ready follows disc_full combinationally so a full FIFO is never overrun.
  always_comb begin
    ready = 2'b00;
    if (state == STREAM && !rst) begin
      ready = bus.grant & {2{!bus.disc_full}};
    end
  end

  assign bus.s_ready      = ready;
  assign bus.disc_wr_en   = |(bus.s_valid & ready);
  assign bus.disc_wr_data = src ? bus.s_data1 : bus.s_data0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      bus.grant       <= 2'b00;
      src             <= 1'b0;
      word_cnt        <= '0;
      wdog            <= '0;
      rd_issued       <= 1'b0;
      real_lat        <= 1'b0;
      bus.disc_start  <= 1'b0;
      bus.score_rd_en <= 1'b0;
      bus.res_valid   <= 1'b0;
      bus.res_src     <= 1'b0;
      bus.res_score   <= '0;
      bus.res_real    <= 1'b0;
      bus.timeout_err <= 1'b0;
    end else begin
      bus.disc_start  <= 1'b0;
      bus.score_rd_en <= 1'b0;
      bus.res_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            bus.grant <= rr_gnt;
            src       <= rr_gnt[1];
            word_cnt  <= '0;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (bus.disc_wr_en) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= START;
          end
        end
        START: begin
          bus.disc_start <= 1'b1;
          wdog           <= '0;
          state          <= WAIT;
        end
        WAIT: begin
          if (bus.disc_done) begin
            real_lat  <= bus.disc_real_flag;
            rd_issued <= 1'b0;
            state     <= READ;
          end else if (wdog == WD_LIMIT) begin
            bus.timeout_err <= 1'b1;
            bus.grant       <= 2'b00;
            state           <= IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        // Read data returns one cycle after rd_en, so only accept it once issued.
        READ: begin
          if (!rd_issued && !bus.score_empty) begin
            bus.score_rd_en <= 1'b1;
            rd_issued       <= 1'b1;
          end
          if (rd_issued && bus.score_rd_valid) begin
            bus.res_valid <= 1'b1;
            bus.res_src   <= src;
            bus.res_score <= bus.score_rd_data;
            bus.res_real  <= real_lat;
            state         <= RESP;
          end
        end
        RESP: begin
          bus.grant <= 2'b00;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
